pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
- Parametrised successor to the plain enable-gated program counter register.
- Holds the fetch PC and selects the next PC from prioritised redirect sources: exception, return, jump, branch, sequential.
- Adds a circular return-address stack (RAS) for call/return redirects.
- Captures the faulting PC on exception. Sits at the head of the fetch stage, feeding instruction memory and the IF/ID register.

Parameters:
- WIDTH, 32, PC and address width in bits.
- RESET_VECTOR, 32'h0000_0000, PC value while and after reset.
- EXC_VECTOR, 32'h8000_0180, PC loaded on exception.
- INC, 4, sequential increment in bytes.
- RAS_DEPTH, 4, return-address stack entries; power of two, at least 2.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  update enable; 0 = stall (hold PC and RAS), except for exceptions.
- exc  input  1  exception request.
- ret  input  1  return redirect (jr $ra class).
- jump  input  1  unconditional jump redirect.
- jump_target  input  WIDTH  jump target; also the fallback return target.
- branch_taken  input  1  taken-branch redirect.
- branch_target  input  WIDTH  branch target.
- call  input  1  push ret_addr onto the RAS.
- ret_addr  input  WIDTH  return address to push.
- pc_out  output  WIDTH  current fetch PC (registered).
- pc_plus  output  WIDTH  pc_out + INC (combinational).
- epc  output  WIDTH  PC captured on the last exception (registered).
- ras_empty  output  1  RAS holds 0 entries.
- ras_full  output  1  RAS holds RAS_DEPTH entries.

Behaviour:
- Reset (async, rst=1):
  - pc_out = RESET_VECTOR; epc = 0.
  - RAS pointer = 0, count = 0; ras_empty = 1, ras_full = 0.
  - RAS storage contents are don't-care.
- Next-PC priority, evaluated each rising edge:
  - exc → EXC_VECTOR, ignoring en.
  - else if en=0 → hold pc_out, epc and the RAS unchanged.
  - else ret → RAS top if count > 0, otherwise jump_target.
  - else jump → jump_target.
  - else branch_taken → branch_target.
  - else → pc_plus.
- Latency: a redirect asserted in cycle N appears on pc_out in cycle N+1. There is no bubble insertion; flushing is owned by the hazard unit.
- Arithmetic: pc_plus wraps modulo 2^WIDTH; no overflow flag.
- Exception:
  - epc <= pc_out (the PC being replaced).
  - RAS count <= 0 (stack flushed).
  - call and ret in the same cycle are ignored.
- RAS operations, only when en=1 and exc=0:
  - Push (call=1, ret=0): write ret_addr at the pointer; pointer <= pointer+1 mod RAS_DEPTH; count <= min(count+1, RAS_DEPTH).
  - Push when full: overwrites the oldest entry via wrap; ras_full stays 1; no error.
  - Pop (ret=1, call=0, count>0): pointer <= pointer-1 mod RAS_DEPTH; count-1.
  - Pop when empty: no state change; the PC takes jump_target.
  - call and ret together: the redirect uses the old top; the top entry is overwritten with ret_addr; pointer and count are unchanged. If empty, behaves as a plain push and the PC takes jump_target.
- call does not redirect the PC on its own. A call normally arrives together with jump, and jump supplies the target.
- ras_empty and ras_full are registered-state decodes of count.
- Reset mid-operation forces reset values immediately, independent of clk.

Decomposition:
- Shared package (mips_pkg):
  - Width constant and the reset/exception vectors.
  - A 3-bit next-PC-source enum: SEQ, BRANCH, JUMP, RET, EXC.
  - This enum is exported on an internal debug net.
- One sub-module, ras_stack:
  - Parametrised circular stack with push, pop, flush, top, empty and full.
  - The PC register, priority mux and epc stay in pc_unit.

Test Plan:
1. Reset and sequential fetch: assert rst mid-cycle → pc_out=0 immediately. Release rst, en=1 for 3 cycles → pc_out 0x4, 0x8, 0xC; pc_plus=0x10.
2. Stall vs exception: en=0 for 2 cycles at pc=0x20 → holds 0x20. en=0 with exc=1 → pc_out=0x8000_0180, epc=0x20, ras_empty=1.
3. Priority: ret=1 (RAS top 0x100), jump=1 (0x200), branch_taken=1 (0x300) in one cycle → pc_out=0x100. Drop ret → next redirect goes to 0x200.
4. RAS wrap: push 0x10, 0x20, 0x30, 0x40, 0x50 (DEPTH=4) → ras_full=1 after the 4th push. Pops return 0x50, 0x40, 0x30, 0x20, then ras_empty=1. A 5th ret with jump_target=0x999 → pc_out=0x999.
5. Simultaneous call+ret with top=0x40 and ret_addr=0x77 → pc_out=0x40, count unchanged; the next ret → 0x77.
6. Wrap-around: pc_out=0xFFFF_FFFC, sequential step → 0x0000_0000.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the fetch-stage PC logic.
//   XLEN      : default PC / address width.
//   RESET_VEC : PC value while and after reset.
//   EXC_VEC   : PC loaded when an exception is taken.
//   pc_src_e  : next-PC source selector, exported on a debug net in pc_unit.
package mips_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [31:0] RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] EXC_VEC   = 32'h8000_0180;

  typedef enum logic [2:0] {
    SrcSeq,
    SrcBranch,
    SrcJump,
    SrcRet,
    SrcExc
  } pc_src_e;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack.
//   clk_i    : rising-edge clock.
//   rst_i    : asynchronous active-high reset (pointer and count only).
//   push_i   : write data_i at the pointer and advance.
//   pop_i    : retreat the pointer when not empty.
//   flush_i  : drop all entries; overrides push/pop.
//   data_i   : return address to push.
//   top_o    : most recently pushed entry (valid when !empty_o).
//   empty_o  : stack holds 0 entries.
//   full_o   : stack holds Depth entries.
// push_i and pop_i together replace the top entry in place (count unchanged);
// on an empty stack that degenerates to a plain push.
module ras_stack #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [Width-1:0] data_i,
  output logic [Width-1:0] top_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [PtrW-1:0]  ptr_q, ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [PtrW-1:0]  top_idx;
  logic [PtrW-1:0]  wr_idx;
  logic             wr_en;
  logic [Width-1:0] mem_q [Depth];

  // Pointer names the next free slot; Depth is a power of two so it wraps freely.
  assign top_idx = ptr_q - PtrW'(1);
  assign top_o   = mem_q[top_idx];
  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CntW'(Depth));

  always_comb begin
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    wr_en  = 1'b0;
    wr_idx = ptr_q;
    if (flush_i) begin
      cnt_d = '0;
    end else if (push_i && pop_i) begin
      wr_en = 1'b1;
      if (empty_o) begin
        ptr_d = ptr_q + PtrW'(1);
        cnt_d = cnt_q + CntW'(1);
      end else begin
        wr_idx = top_idx;
      end
    end else if (push_i) begin
      // When full the write lands on the oldest entry and count saturates.
      wr_en = 1'b1;
      ptr_d = ptr_q + PtrW'(1);
      if (!full_o) begin
        cnt_d = cnt_q + CntW'(1);
      end
    end else if (pop_i && !empty_o) begin
      ptr_d = ptr_q - PtrW'(1);
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[wr_idx] <= data_i;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Fetch program counter with prioritised redirects and a return-address stack.
//   clk, rst       : rising-edge clock, asynchronous active-high reset.
//   en             : update enable; 0 stalls PC/RAS except for exceptions.
//   exc            : exception request (highest priority, ignores en).
//   ret            : return redirect to RAS top (jump_target if RAS empty).
//   jump           : unconditional redirect to jump_target.
//   jump_target    : jump target and fallback return target.
//   branch_taken   : redirect to branch_target.
//   call           : push ret_addr onto the RAS (no redirect by itself).
//   ret_addr       : return address to push.
//   pc_out         : registered fetch PC.
//   pc_plus        : pc_out + INC, wrapping.
//   epc            : PC replaced by the most recent exception.
//   ras_empty/full : RAS occupancy decodes.
module pc_unit
  import mips_pkg::*;
#(
  parameter int unsigned     WIDTH        = XLEN,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(RESET_VEC),
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(EXC_VEC),
  parameter int unsigned     INC          = 4,
  parameter int unsigned     RAS_DEPTH    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             exc,
  input  logic             ret,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             call,
  input  logic [WIDTH-1:0] ret_addr,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] pc_plus,
  output logic [WIDTH-1:0] epc,
  output logic             ras_empty,
  output logic             ras_full
);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic [WIDTH-1:0] ras_top;
  logic             ras_push, ras_pop, ras_flush;
  logic             hold;
  pc_src_e          next_src_dbg;

  assign pc_out  = pc_q;
  assign pc_plus = pc_q + WIDTH'(INC);
  assign epc     = epc_q;

  // Source selection and RAS control.
  always_comb begin
    next_src_dbg = SrcSeq;
    hold         = 1'b0;
    epc_d        = epc_q;
    ras_push     = 1'b0;
    ras_pop      = 1'b0;
    ras_flush    = 1'b0;
    if (exc) begin
      next_src_dbg = SrcExc;
      epc_d        = pc_q;
      ras_flush    = 1'b1;
    end else if (!en) begin
      hold = 1'b1;
    end else begin
      ras_push = call;
      ras_pop  = ret;
      if (ret) begin
        next_src_dbg = SrcRet;
      end else if (jump) begin
        next_src_dbg = SrcJump;
      end else if (branch_taken) begin
        next_src_dbg = SrcBranch;
      end
    end
  end

  // Next-PC mux driven by the selected source.
  always_comb begin
    pc_d = pc_plus;
    if (hold) begin
      pc_d = pc_q;
    end else begin
      unique case (next_src_dbg)
        SrcExc:    pc_d = EXC_VECTOR;
        SrcRet:    pc_d = ras_empty ? jump_target : ras_top;
        SrcJump:   pc_d = jump_target;
        SrcBranch: pc_d = branch_target;
        SrcSeq:    pc_d = pc_plus;
        default:   pc_d = pc_plus;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q  <= RESET_VECTOR;
      epc_q <= '0;
    end else begin
      pc_q  <= pc_d;
      epc_q <= epc_d;
    end
  end

  ras_stack #(
    .Width (WIDTH),
    .Depth (RAS_DEPTH)
  ) u_ras (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (ras_push),
    .pop_i   (ras_pop),
    .flush_i (ras_flush),
    .data_i  (ret_addr),
    .top_o   (ras_top),
    .empty_o (ras_empty),
    .full_o  (ras_full)
  );

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

  logic        clk;
  logic        rst;
  logic        en;
  logic        exc;
  logic        ret;
  logic        jump;
  logic [31:0] jump_target;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        call;
  logic [31:0] ret_addr;
  logic [31:0] pc_out;
  logic [31:0] pc_plus;
  logic [31:0] epc;
  logic        ras_empty;
  logic        ras_full;

  int n_cmp = 0;
  int n_bad = 0;

  pc_unit dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .exc           (exc),
    .ret           (ret),
    .jump          (jump),
    .jump_target   (jump_target),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .call          (call),
    .ret_addr      (ret_addr),
    .pc_out        (pc_out),
    .pc_plus       (pc_plus),
    .epc           (epc),
    .ras_empty     (ras_empty),
    .ras_full      (ras_full)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    en = 1'b1; exc = 1'b0; ret = 1'b0; jump = 1'b0; branch_taken = 1'b0; call = 1'b0;
    jump_target = '0; branch_target = '0; ret_addr = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_in();
    #12 rst = 1'b0;
    tick();
    tick();
    // Mid-cycle reset must act without a clock edge.
    #3 rst = 1'b1;
    #1;
    n_cmp++; if (pc_out !== 32'h0) begin n_bad++; $display("FAIL reset_pc got %h want %h", pc_out, 32'h0); end
    n_cmp++; if (epc !== 32'h0) begin n_bad++; $display("FAIL reset_epc got %h want %h", epc, 32'h0); end
    n_cmp++; if (ras_empty !== 1'b1) begin n_bad++; $display("FAIL reset_empty got %b want 1", ras_empty); end
    n_cmp++; if (ras_full !== 1'b0) begin n_bad++; $display("FAIL reset_full got %b want 0", ras_full); end
    #2 rst = 1'b0;
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc [3];
    exp_pc = '{32'h4, 32'h8, 32'hC};
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (pc_out !== exp_pc[i]) begin
        n_bad++; $display("FAIL seq_pc[%0d] got %h want %h", i, pc_out, exp_pc[i]);
      end
    end
    n_cmp++; if (pc_plus !== 32'h10) begin n_bad++; $display("FAIL seq_pc_plus got %h want %h", pc_plus, 32'h10); end
  endtask

  task automatic test_stall_exc();
    call = 1'b1; ret_addr = 32'h55; jump = 1'b1; jump_target = 32'h20;
    tick();
    n_cmp++; if (pc_out !== 32'h20) begin n_bad++; $display("FAIL call_jump_pc got %h want %h", pc_out, 32'h20); end
    n_cmp++; if (ras_empty !== 1'b0) begin n_bad++; $display("FAIL call_nonempty got %b want 0", ras_empty); end
    // Stalled with redirects present: everything holds.
    en = 1'b0; call = 1'b1; ret_addr = 32'h66; jump = 1'b1; jump_target = 32'h444;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++;
      if (pc_out !== 32'h20) begin n_bad++; $display("FAIL stall_pc[%0d] got %h want %h", i, pc_out, 32'h20); end
    end
    call = 1'b0; jump = 1'b0; exc = 1'b1;
    tick();
    n_cmp++; if (pc_out !== 32'h8000_0180) begin n_bad++; $display("FAIL exc_pc got %h want %h", pc_out, 32'h8000_0180); end
    n_cmp++; if (epc !== 32'h20) begin n_bad++; $display("FAIL exc_epc got %h want %h", epc, 32'h20); end
    n_cmp++; if (ras_empty !== 1'b1) begin n_bad++; $display("FAIL exc_flush got %b want 1", ras_empty); end
    clear_in();
  endtask

  task automatic test_priority();
    call = 1'b1; ret_addr = 32'h100;
    tick();
    call = 1'b0;
    ret = 1'b1; jump = 1'b1; jump_target = 32'h200; branch_taken = 1'b1; branch_target = 32'h300;
    tick();
    n_cmp++; if (pc_out !== 32'h100) begin n_bad++; $display("FAIL prio_ret got %h want %h", pc_out, 32'h100); end
    n_cmp++; if (ras_empty !== 1'b1) begin n_bad++; $display("FAIL prio_popped got %b want 1", ras_empty); end
    ret = 1'b0;
    tick();
    n_cmp++; if (pc_out !== 32'h200) begin n_bad++; $display("FAIL prio_jump got %h want %h", pc_out, 32'h200); end
    jump = 1'b0;
    tick();
    n_cmp++; if (pc_out !== 32'h300) begin n_bad++; $display("FAIL prio_branch got %h want %h", pc_out, 32'h300); end
    clear_in();
  endtask

  task automatic test_ras_wrap();
    logic [31:0] exp_pop [4];
    exp_pop = '{32'h50, 32'h40, 32'h30, 32'h20};
    for (int i = 1; i <= 5; i++) begin
      call = 1'b1; ret_addr = 32'(i * 16);
      tick();
      if (i == 3) begin
        n_cmp++; if (ras_full !== 1'b0) begin n_bad++; $display("FAIL wrap_full3 got %b want 0", ras_full); end
      end
      if (i >= 4) begin
        n_cmp++; if (ras_full !== 1'b1) begin n_bad++; $display("FAIL wrap_full%0d got %b want 1", i, ras_full); end
      end
    end
    call = 1'b0; ret = 1'b1; jump_target = 32'h999;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if (pc_out !== exp_pop[i]) begin n_bad++; $display("FAIL wrap_pop[%0d] got %h want %h", i, pc_out, exp_pop[i]); end
    end
    n_cmp++; if (ras_empty !== 1'b1) begin n_bad++; $display("FAIL wrap_empty got %b want 1", ras_empty); end
    tick();
    n_cmp++; if (pc_out !== 32'h999) begin n_bad++; $display("FAIL wrap_fallback got %h want %h", pc_out, 32'h999); end
    clear_in();
  endtask

  task automatic test_call_ret();
    call = 1'b1; ret_addr = 32'h30;
    tick();
    ret_addr = 32'h40;
    tick();
    ret = 1'b1; ret_addr = 32'h77;
    tick();
    n_cmp++; if (pc_out !== 32'h40) begin n_bad++; $display("FAIL callret_pc got %h want %h", pc_out, 32'h40); end
    n_cmp++; if (ras_empty !== 1'b0) begin n_bad++; $display("FAIL callret_empty got %b want 0", ras_empty); end
    call = 1'b0; jump_target = 32'hBAD0;
    tick();
    n_cmp++; if (pc_out !== 32'h77) begin n_bad++; $display("FAIL callret_pop1 got %h want %h", pc_out, 32'h77); end
    tick();
    n_cmp++; if (pc_out !== 32'h30) begin n_bad++; $display("FAIL callret_pop2 got %h want %h", pc_out, 32'h30); end
    n_cmp++; if (ras_empty !== 1'b1) begin n_bad++; $display("FAIL callret_empty2 got %b want 1", ras_empty); end
    clear_in();
  endtask

  task automatic test_reset_mid_op();
    call = 1'b1; ret_addr = 32'h5;
    tick();
    call = 1'b0;
    #3 rst = 1'b1;
    #1;
    n_cmp++; if (pc_out !== 32'h0) begin n_bad++; $display("FAIL midrst_pc got %h want %h", pc_out, 32'h0); end
    n_cmp++; if (epc !== 32'h0) begin n_bad++; $display("FAIL midrst_epc got %h want %h", epc, 32'h0); end
    n_cmp++; if (ras_empty !== 1'b1) begin n_bad++; $display("FAIL midrst_empty got %b want 1", ras_empty); end
    #2 rst = 1'b0;
  endtask

  task automatic test_wrap_around();
    jump = 1'b1; jump_target = 32'hFFFF_FFFC;
    tick();
    n_cmp++; if (pc_out !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_jump got %h want %h", pc_out, 32'hFFFF_FFFC); end
    n_cmp++; if (pc_plus !== 32'h0) begin n_bad++; $display("FAIL wrap_plus got %h want %h", pc_plus, 32'h0); end
    jump = 1'b0;
    tick();
    n_cmp++; if (pc_out !== 32'h0) begin n_bad++; $display("FAIL wrap_seq got %h want %h", pc_out, 32'h0); end
    clear_in();
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall_exc();
    test_priority();
    test_ras_wrap();
    test_call_ret();
    test_reset_mid_op();
    test_wrap_around();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
